// File: rtl/seg_display_scanner_if.sv
// Value-in / display-out bus of seg_display_scanner.
// Carries the brightness input only when SEG_BRIGHTNESS_EN is defined.
interface seg_display_scanner_if #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 32
);
   logic [VALUE_W-1:0]    value;
   logic [1:0]            mode;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic                  load;
   logic                  busy;
   logic                  overflow;
   logic [6:0]            seg_out;
   logic                  dp_out;
   logic [NUM_DIGITS-1:0] cs_out;
`ifdef SEG_BRIGHTNESS_EN
   logic [3:0]            brightness;
`endif

   modport master (
`ifdef SEG_BRIGHTNESS_EN
      output brightness,
`endif
      output value, mode, blank_lz, dp_mask, load,
      input  busy, overflow, seg_out, dp_out, cs_out
   );

   modport slave (
`ifdef SEG_BRIGHTNESS_EN
      input  brightness,
`endif
      input  value, mode, blank_lz, dp_mask, load,
      output busy, overflow, seg_out, dp_out, cs_out
   );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment driver: hex / unsigned / signed decimal via a serial double-dabble.
// Optional macro SEG_BRIGHTNESS_EN adds a 4-bit PWM brightness input on the bus.
module seg_display_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 32,
   parameter int SCAN_DIV   = 10000
) (
   input  logic                 clk,
   input  logic                 rst,
   seg_display_scanner_if.slave bus
);
   localparam int BCD_DIGITS = (VALUE_W*3)/10+1;
   localparam int BCD_W      = BCD_DIGITS*4;
   localparam int CNT_W      = $clog2(VALUE_W+1);
   localparam int SCAN_W     = $clog2(SCAN_DIV);
   localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
   localparam logic [6:0] GLYPH_MINUS = 7'b0000001;
   localparam logic [6:0] GLYPH_E     = 7'b1001111;
   localparam logic [6:0] GLYPH_R     = 7'b0000101;

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t                         state_q, state_d;
   logic [VALUE_W-1:0]             val_q, val_d;
   logic [BCD_W-1:0]               bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
   logic                           hex_q, hex_d, neg_q, neg_d, blz_q, blz_d;
   logic                           ovf_q, ovf_d, ovf_new;
   logic [NUM_DIGITS-1:0][6:0]     buf_q, buf_d, buf_new;
   logic [NUM_DIGITS-1:0][3:0]     nib;
   int                             msd;
   logic                           dec_in, neg_in;

   logic [SCAN_W-1:0]              scan_q, scan_d;
   logic [DIG_W-1:0]               dig_q, dig_d;
   logic                           scan_tc;
   logic [6:0]                     seg_q;
   logic                           dp_q;
   logic [NUM_DIGITS-1:0]          cs_q, cs_d;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < BCD_DIGITS; i++)
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      return r;
   endfunction

`ifdef SEG_BRIGHTNESS_EN
   function automatic logic [31:0] duty_limit(input logic [3:0] b);
      logic [31:0] prod;
      prod = (32'(b) + 32'd1) * 32'(SCAN_DIV);
      return prod >> 4;
   endfunction
`endif

   assign dec_in  = (bus.mode == 2'b01) || (bus.mode == 2'b10);
   assign neg_in  = (bus.mode == 2'b10) && bus.value[VALUE_W-1];
   assign bcd_adj = bcd_adjust(bcd_q);

   // Control FSM and serial conversion
   always_comb begin
      state_d   = state_q;
      val_d     = val_q;
      bcd_d     = bcd_q;
      bit_cnt_d = bit_cnt_q;
      hex_d     = hex_q;
      neg_d     = neg_q;
      blz_d     = blz_q;
      buf_d     = buf_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               hex_d     = !dec_in;
               neg_d     = neg_in;
               blz_d     = bus.blank_lz;
               val_d     = neg_in ? -bus.value : bus.value;
               bcd_d     = '0;
               bit_cnt_d = '0;
               state_d   = dec_in ? CONVERT : COMMIT;
            end
         end
         CONVERT: begin
            bcd_d     = {bcd_adj[BCD_W-2:0], val_q[VALUE_W-1]};
            val_d     = val_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(VALUE_W-1)) state_d = COMMIT;
         end
         COMMIT: begin
            buf_d   = buf_new;
            ovf_d   = ovf_new;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Glyph composition from the converted (or raw hex) digits
   always_comb begin
      nib     = '0;
      ovf_new = 1'b0;
      msd     = 0;
      buf_new = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         for (int b = 0; b < 4; b++) begin
            if (hex_q) begin
               if (4*k+b < VALUE_W) nib[k][b] = val_q[4*k+b];
            end else begin
               if (4*k+b < BCD_W) nib[k][b] = bcd_q[4*k+b];
            end
         end
      end
      // A negative value needs the leftmost digit free for the minus sign.
      if (!hex_q) begin
         for (int i = 0; i < BCD_DIGITS; i++)
            if ((i >= NUM_DIGITS || (neg_q && i == NUM_DIGITS-1)) && bcd_q[4*i +: 4] != 4'd0)
               ovf_new = 1'b1;
      end
      for (int k = 0; k < NUM_DIGITS; k++)
         if (nib[k] != 4'd0) msd = k;
      if (ovf_new) begin
         for (int k = 0; k < NUM_DIGITS; k++)
            buf_new[k] = (k == NUM_DIGITS-1) ? GLYPH_E :
                         (k == NUM_DIGITS-2 || k == NUM_DIGITS-3) ? GLYPH_R : GLYPH_BLANK;
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            buf_new[k] = (blz_q && k > msd) ? GLYPH_BLANK : hex_glyph(nib[k]);
            if (neg_q && k == (blz_q ? msd + 1 : NUM_DIGITS - 1)) buf_new[k] = GLYPH_MINUS;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ovf_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         buf_q   <= buf_d;
      end
   end

   always_ff @(posedge clk) begin
      val_q     <= val_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      hex_q     <= hex_d;
      neg_q     <= neg_d;
      blz_q     <= blz_d;
   end

   // Digit scan and registered display outputs
   assign scan_tc = (scan_q == SCAN_W'(SCAN_DIV-1));

   always_comb begin
      scan_d = scan_q + 1'b1;
      dig_d  = dig_q;
      if (scan_tc) begin
         scan_d = '0;
         dig_d  = (dig_q == DIG_W'(NUM_DIGITS-1)) ? '0 : dig_q + 1'b1;
      end
   end

`ifdef SEG_BRIGHTNESS_EN
   logic [3:0] bright_q, bright_d;
   assign bright_d = scan_tc ? bus.brightness : bright_q;

   always_ff @(posedge clk) begin
      if (rst) bright_q <= 4'hF;
      else     bright_q <= bright_d;
   end
`endif

   always_comb begin
      cs_d = ~(NUM_DIGITS'(1) << dig_d);
`ifdef SEG_BRIGHTNESS_EN
      if (32'(scan_d) >= duty_limit(bright_d)) cs_d = '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= '0;
         dig_q  <= '0;
         seg_q  <= '0;
         dp_q   <= 1'b0;
         cs_q   <= ~NUM_DIGITS'(1);
      end else begin
         scan_q <= scan_d;
         dig_q  <= dig_d;
         seg_q  <= buf_q[dig_d];
         dp_q   <= bus.dp_mask[dig_d] & ~ovf_q;
         cs_q   <= cs_d;
      end
   end

   assign bus.busy     = (state_q == CONVERT);
   assign bus.overflow = ovf_q;
   assign bus.seg_out  = seg_q;
   assign bus.dp_out   = dp_q;
   assign bus.cs_out   = cs_q;
endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Parametrised multiplexed seven-segment driver; next generation of the existing fixed 4-digit hex and int32 display drivers.
- Captures a value on request, converts it in hex, unsigned-decimal or signed-decimal mode, and scan-drives NUM_DIGITS common-select digits.
- Decimal conversion is a sequential double-dabble engine, not combinational divide/modulo.
- Sits at top level beside the RISC-V core; feeds its debug/result value to the board displays.

Parameters:
- NUM_DIGITS, 4, number of displayed digits (1..8); digit 0 is rightmost.
- VALUE_W, 32, width of the input value (4..32).
- SCAN_DIV, 10000, clk cycles each digit is held active (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- value  in  VALUE_W  value to display, sampled on load.
- mode  in  2  00 hex, 01 unsigned decimal, 10 signed decimal, 11 treated as hex; sampled on load.
- blank_lz  in  1  blank leading zeros; sampled on load.
- dp_mask  in  NUM_DIGITS  per-digit decimal point, live (not sampled).
- load  in  1  single-cycle capture request.
- busy  out  1  conversion in progress.
- overflow  out  1  last committed value did not fit.
- seg_out  out  7  segments a..g, bit6=a, bit0=g, active-high.
- dp_out  out  1  decimal point of the active digit.
- cs_out  out  NUM_DIGITS  digit select, active-low, one-hot-low.

Behaviour:
- Reset: busy=0, overflow=0, display buffer all blank (seg_out=0, dp_out=0), scan counter=0, active digit=0 (cs_out = all ones except bit0 = 0). Reset mid-conversion aborts it; the buffer is not updated.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE + load: capture value, mode and blank_lz. Hex goes to COMMIT; decimal goes to CONVERT with busy=1 from the next cycle.
  - CONVERT: one shift per cycle for exactly VALUE_W cycles, then COMMIT.
  - COMMIT: one cycle; writes the whole buffer atomically, clears busy, returns to IDLE.
- Latency from the load edge to buffer update: hex 2 cycles; decimal VALUE_W+2 cycles.
- load while busy=1 or in COMMIT is ignored; no queueing.
- Hex mode: nibble k of the value goes to digit k; nibbles at or above NUM_DIGITS are dropped, with no overflow. Glyphs 0-9 and A-F use the existing encoding (0=1111110, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111).
- Decimal BCD width: localparam BCD_DIGITS = (VALUE_W*3)/10+1.
- Signed mode: magnitude = two's complement of value if MSB=1. The most negative value yields magnitude 2^(VALUE_W-1) without overflow internally.
- Overflow:
  - Unsigned: magnitude >= 10^NUM_DIGITS.
  - Signed negative: magnitude >= 10^(NUM_DIGITS-1).
  - On overflow, display leftmost 'E' (1001111), the next up to two digits 'r' (0000101), the rest blank, and set overflow=1.
  - Any non-overflowing commit clears overflow.
- Blanking: with blank_lz=1, zero digits left of the most significant nonzero digit are blank; digit 0 always shows, so value 0 displays "0".
- Minus sign (0000001): with blank_lz=1, placed immediately left of the most significant shown digit; with blank_lz=0, placed in the leftmost digit.
- Scan: counter runs 0..SCAN_DIV-1; at terminal count the active digit advances k -> k+1, wrapping NUM_DIGITS-1 -> 0. Exactly one cs_out bit is low at all times.
- Outputs: seg_out, dp_out and cs_out are registered and change on the same edge. dp_out = dp_mask[active digit], suppressed while the digit shows the overflow pattern.
- Scanning continues during conversion; the old buffer is shown until COMMIT.

Optional Feature:
- Macro: SEG_BRIGHTNESS_EN.
- Defined: adds input port brightness[3:0]. The active digit's cs bit is low only while scan counter < ((brightness+1)*SCAN_DIV)>>4, otherwise all cs_out bits are high. brightness=15 gives full duty. brightness is sampled at each digit advance.
- Undefined: no port; full duty, identical to brightness=15.

Test Plan:
- Reset, NUM_DIGITS=4, SCAN_DIV=4 -> cs_out=1110, seg_out=0, busy=0; after 4 clks cs_out=1101; after 16 clks back to 1110.
- Hex, load value=32'h0000BEEF -> 2 clks later digits 3..0 show b,E,E,F; busy never asserts; overflow=0.
- Unsigned decimal, value=1234, blank_lz=1 -> busy high for 32 clks, then digits "1234"; then value=7 -> digits 3..1 blank, digit 0 shows "7".
- Signed decimal, value=-42 (32'hFFFFFFD6), blank_lz=1 -> digits blank,'-','4','2'; value=-1000 -> overflow=1, display 'E','r','r',blank.
- load pulsed again at cycle 5 of a conversion -> ignored; the first value commits at VALUE_W+2; reset at cycle 10 of a conversion -> busy=0 next clk, buffer blank.
- With SEG_BRIGHTNESS_EN, SCAN_DIV=16, brightness=3 -> each digit's cs is low for 4 of 16 clks.
